// File: rtl/sw_pkg.sv
// Shared constants for the switch/button input peripheral: register sub-addresses
// and the debounce counter width helper.
package sw_pkg;

   localparam logic [1:0] SW_ADDR_SWITCH = 2'b00;
   localparam logic [1:0] SW_ADDR_BTN    = 2'b01;
   localparam logic [1:0] SW_ADDR_FLAGS  = 2'b10;
   localparam logic [1:0] SW_ADDR_COUNT  = 2'b11;

   // Bits needed to hold 0 .. n-1; never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One-bit 2-flop synchroniser followed by a stability-counting debouncer.
// With SW_DEBOUNCE_EN undefined the counter is removed and the synchroniser output is used directly.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic ledclk,
   input  logic ledrst,
   input  logic din,
   output logic dout
);

   if (DEBOUNCE_CYCLES < 2) begin : g_dc_check
      $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2");
   end

   logic sync_p0;
   logic sync_p1;

   // Synchroniser stage: din is asynchronous to ledclk
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

`ifdef SW_DEBOUNCE_EN
   localparam int CNT_W = sw_pkg::clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             stable;

   // Debounce stage: accept a new level only after it persists DEBOUNCE_CYCLES edges
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync_p1 != stable) begin
         if (cnt == CNT_MAX) begin
            stable <= sync_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   assign dout = stable;
`else
   assign dout = sync_p1;
`endif

endmodule

// File: rtl/switch_reader.sv
// Memory-mapped switch/button reader on the LED IO bus: debounced levels, sticky press flags
// (clear-on-read) and a press counter. Debouncing is enabled by defining SW_DEBOUNCE_EN.
module switch_reader
   import sw_pkg::*;
#(
   parameter int SW_W            = 16,
   parameter int BTN_W           = 5,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic             ledclk,
   input  logic             ledrst,
   input  logic             swcs,
   input  logic             swread,
   input  logic [1:0]       swaddr,
   input  logic [SW_W-1:0]  swin,
   input  logic [BTN_W-1:0] btnin,
   output logic [15:0]      swoutdata
);

   localparam int IN_W = SW_W + BTN_W;

   logic [IN_W-1:0]  raw_in;
   logic [IN_W-1:0]  deb;
   logic [SW_W-1:0]  sw_stable;
   logic [BTN_W-1:0] btn_stable;
   logic [BTN_W-1:0] btn_prev;
   logic [BTN_W-1:0] rise;
   logic [BTN_W-1:0] press_flags;
   logic [15:0]      press_count;
   logic [15:0]      rdata;
   logic             rd;

   assign raw_in = {btnin, swin};

   for (genvar i = 0; i < IN_W; i++) begin : g_in
      sw_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .ledclk (ledclk),
         .ledrst (ledrst),
         .din    (raw_in[i]),
         .dout   (deb[i])
      );
   end

   assign sw_stable  = deb[SW_W-1:0];
   assign btn_stable = deb[IN_W-1:SW_W];
   assign rise       = btn_stable & ~btn_prev;
   assign rd         = swcs & swread;

   always_comb begin
      rdata = '0;
      case (swaddr)
         SW_ADDR_SWITCH: rdata = 16'(sw_stable);
         SW_ADDR_BTN:    rdata = 16'(btn_stable);
         SW_ADDR_FLAGS:  rdata = 16'(press_flags);
         SW_ADDR_COUNT:  rdata = press_count;
         default:        rdata = '0;
      endcase
   end

   // Press capture and read-data register; a press landing on a flags read survives the clear
   always_ff @(posedge ledclk or posedge ledrst) begin
      if (ledrst) begin
         btn_prev    <= '0;
         press_flags <= '0;
         press_count <= '0;
         swoutdata   <= '0;
      end else begin
         btn_prev <= btn_stable;
         if (|rise) press_count <= press_count + 16'd1;
         if (rd && (swaddr == SW_ADDR_FLAGS)) press_flags <= rise;
         else                                  press_flags <= press_flags | rise;
         if (rd) swoutdata <= rdata;
      end
   end

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboard bench for switch_reader with DEBOUNCE_CYCLES=4; expected read data is queued
// when each read is issued and popped when the registered output is valid.
module tb_switch_reader;

   localparam int DC = 4;
`ifdef SW_DEBOUNCE_EN
   localparam int LAT = 2 + DC;
`else
   localparam int LAT = 2;
`endif
   localparam int SETTLE = LAT + 3;

   logic        ledclk = 1'b0;
   logic        ledrst = 1'b1;
   logic        swcs   = 1'b0;
   logic        swread = 1'b0;
   logic [1:0]  swaddr = 2'b00;
   logic [15:0] swin   = 16'h0000;
   logic [4:0]  btnin  = 5'b00000;
   logic [15:0] swoutdata;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e;
   logic [15:0] mcount;

   always #5 ledclk = ~ledclk;

   switch_reader #(
      .SW_W            (16),
      .BTN_W           (5),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .ledclk    (ledclk),
      .ledrst    (ledrst),
      .swcs      (swcs),
      .swread    (swread),
      .swaddr    (swaddr),
      .swin      (swin),
      .btnin     (btnin),
      .swoutdata (swoutdata)
   );

   task automatic idle(input int n);
      repeat (n) @(negedge ledclk);
   endtask

   // One-cycle chip-selected read; returns #1 after the sampling edge
   task automatic rd(input logic [1:0] a, input logic [15:0] ex);
      exp_q.push_back(ex);
      @(negedge ledclk);
      swcs   = 1'b1;
      swread = 1'b1;
      swaddr = a;
      @(posedge ledclk);
      #1;
      swcs   = 1'b0;
      swread = 1'b0;
   endtask

   task automatic press(input logic [4:0] m);
      @(negedge ledclk);
      btnin = m;
      idle(SETTLE);
      btnin = 5'b00000;
      idle(SETTLE);
   endtask

   task automatic test_reset;
      @(negedge ledclk);
      swin  = 16'hFFFF;
      btnin = 5'b11111;
      idle(4);
      #2 ledrst = 1'b1;
      swin  = 16'h0000;
      btnin = 5'b00000;
      idle(3);
      ledrst = 1'b0;
      mcount = 16'h0000;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), 16'h0000);
         e = exp_q.pop_front(); tests++;
         if (swoutdata !== e) begin fails++; $display("FAIL reset_addr%0d: got %h want %h", a, swoutdata, e); end
      end
   endtask

   task automatic test_switches;
      @(negedge ledclk);
      swin = 16'hA5A5;
      idle(8 + LAT);
      rd(2'b00, 16'hA5A5);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL sw_a5a5: got %h want %h", swoutdata, e); end
`ifdef SW_DEBOUNCE_EN
      @(negedge ledclk);
      swin = 16'hA5A4;
      idle(3);
      swin = 16'hA5A5;
      idle(SETTLE);
      rd(2'b00, 16'hA5A5);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL sw_glitch_rejected: got %h want %h", swoutdata, e); end
`else
      @(negedge ledclk);
      swin = 16'hA5A4;
      @(negedge ledclk);
      swin = 16'hA5A5;
      rd(2'b00, 16'hA5A4);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL sw_pulse_seen: got %h want %h", swoutdata, e); end
      rd(2'b00, 16'hA5A5);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL sw_pulse_gone: got %h want %h", swoutdata, e); end
`endif
   endtask

   task automatic test_press;
      @(negedge ledclk);
      btnin = 5'b00100;
      idle(SETTLE);
      rd(2'b01, 16'h0004);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL btn_level: got %h want %h", swoutdata, e); end
      btnin = 5'b00000;
      idle(SETTLE);
      mcount = mcount + 16'd1;
      rd(2'b10, 16'h0004);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL flags_first: got %h want %h", swoutdata, e); end
      rd(2'b10, 16'h0000);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL flags_cleared: got %h want %h", swoutdata, e); end
      rd(2'b11, mcount);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL count_one: got %h want %h", swoutdata, e); end
   endtask

   task automatic test_clear_race;
      @(negedge ledclk);
      btnin = 5'b00010;
      idle(LAT - 1);
      rd(2'b10, 16'h0000);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL race_old_flags: got %h want %h", swoutdata, e); end
      rd(2'b10, 16'h0002);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL race_new_flag: got %h want %h", swoutdata, e); end
      btnin = 5'b00000;
      idle(SETTLE);
      mcount = mcount + 16'd1;
   endtask

   task automatic test_multi;
      press(5'b01001);
      mcount = mcount + 16'd1;
      rd(2'b10, 16'h0009);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL multi_flags: got %h want %h", swoutdata, e); end
      rd(2'b11, mcount);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL multi_count: got %h want %h", swoutdata, e); end
   endtask

   task automatic test_wrap;
      @(negedge ledclk);
      force dut.press_count = 16'hFFFF;
      @(negedge ledclk);
      release dut.press_count;
      mcount = 16'hFFFF;
      press(5'b10000);
      mcount = mcount + 16'd1;
      rd(2'b11, mcount);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL count_wrap: got %h want %h", swoutdata, e); end
      rd(2'b10, 16'h0010);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL wrap_flags: got %h want %h", swoutdata, e); end
   endtask

   task automatic test_no_cs;
      press(5'b00100);
      mcount = mcount + 16'd1;
      rd(2'b00, 16'hA5A5);
      e = exp_q.pop_front();
      exp_q.push_back(e);
      @(negedge ledclk);
      swcs   = 1'b0;
      swread = 1'b1;
      swaddr = 2'b10;
      @(posedge ledclk);
      #1 swread = 1'b0;
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL nocs_hold: got %h want %h", swoutdata, e); end
      rd(2'b10, 16'h0004);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL nocs_flags_kept: got %h want %h", swoutdata, e); end
   endtask

   task automatic test_back_to_back;
      rd(2'b11, mcount);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL b2b_count: got %h want %h", swoutdata, e); end
      rd(2'b01, 16'h0000);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL b2b_btn: got %h want %h", swoutdata, e); end
      rd(2'b00, 16'hA5A5);
      e = exp_q.pop_front(); tests++;
      if (swoutdata !== e) begin fails++; $display("FAIL b2b_sw: got %h want %h", swoutdata, e); end
   endtask

   task automatic test_reset_mid;
      @(negedge ledclk);
      btnin = 5'b00001;
      idle(2);
      #2 ledrst = 1'b1;
      #1;
      tests++;
      if (swoutdata !== 16'h0000) begin fails++; $display("FAIL async_reset: got %h want %h", swoutdata, 16'h0000); end
      swin  = 16'h0000;
      btnin = 5'b00000;
      idle(3);
      ledrst = 1'b0;
      mcount = 16'h0000;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), (a == 3) ? mcount : 16'h0000);
         e = exp_q.pop_front(); tests++;
         if (swoutdata !== e) begin fails++; $display("FAIL post_reset_addr%0d: got %h want %h", a, swoutdata, e); end
      end
   endtask

   initial begin
      mcount = 16'h0000;
      idle(3);
      ledrst = 1'b0;
      test_reset;
      test_switches;
      test_press;
      test_clear_race;
      test_multi;
      test_wrap;
      test_no_cs;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
